kbd_event_disp: RTL

KBD_EVENT_DISP -- requirements
Module: kbd_event_disp

---
 rtl/kbd_pkg.sv | 15 +
 rtl/kbd_event_disp_if.sv | 10 +
 rtl/hex7seg.sv | 28 ++
 rtl/kbd_event_disp.sv | 116 +++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 set-2 key event display.
package kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kbd_state_e;

  localparam logic [7:0] KBD_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] KBD_PREFIX_BRK = 8'hF0;
  localparam logic [7:0] SEG_BLANK      = 8'hFF;

endpackage

// File: rtl/kbd_event_disp_if.sv
// Scan-code byte stream from the PS/2 receiver into the event display.
// Handshake: code is meaningful only in a cycle with code_valid=1; there is no
// ready, the sink takes every valid byte.
interface kbd_event_disp_if;
  logic       code_valid;
  logic [7:0] code;

  modport master (output code_valid, output code);
  modport slave  (input  code_valid, input  code);
endinterface

// File: rtl/hex7seg.sv
// Nibble to 7-segment decode; active-low, bit0..6 = a..g, bit7 = dp (off).
module hex7seg (
  input  logic [3:0] nib,
  output logic [7:0] seg_n
);
  always_comb begin
    seg_n = 8'hFF;
    case (nib)
      4'h0: seg_n = 8'hC0;
      4'h1: seg_n = 8'hF9;
      4'h2: seg_n = 8'hA4;
      4'h3: seg_n = 8'hB0;
      4'h4: seg_n = 8'h99;
      4'h5: seg_n = 8'h92;
      4'h6: seg_n = 8'h82;
      4'h7: seg_n = 8'hF8;
      4'h8: seg_n = 8'h80;
      4'h9: seg_n = 8'h90;
      4'hA: seg_n = 8'h88;
      4'hB: seg_n = 8'h83;
      4'hC: seg_n = 8'hC6;
      4'hD: seg_n = 8'hA1;
      4'hE: seg_n = 8'h86;
      4'hF: seg_n = 8'h8E;
      default: seg_n = 8'hFF;
    endcase
  end
endmodule

// File: rtl/kbd_event_disp.sv
// PS/2 set-2 parser: tracks the held key and a press counter, and drives
// registered 7-segment bytes for key (2 digits) and counter.
module kbd_event_disp
  import kbd_pkg::*;
#(
  parameter int CNT_DIGITS       = 2,
  parameter bit BLANK_ON_RELEASE = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  kbd_event_disp_if.slave           kin,
  output logic [7:0]                key_code,
  output logic                      key_ext,
  output logic                      pressed,
  output logic [4*CNT_DIGITS-1:0]   count,
  output logic [8*(2+CNT_DIGITS)-1:0] seg,
  output kbd_state_e                state_dbg
);
  localparam int NDIG = 2 + CNT_DIGITS;
  localparam int CW   = 4 * CNT_DIGITS;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [7:0]    POL_MASK = SEG_ACTIVE_LOW ? 8'h00 : 8'hFF;

  kbd_state_e      state_q, state_d;
  logic [7:0]      key_q, key_d;
  logic            ext_q, ext_d;
  logic            pressed_q, pressed_d;
  logic [CW-1:0]   count_q, count_d;
  logic [8*NDIG-1:0] seg_q, seg_d, seg_rst;

  logic       is_ext, is_brk, hit_held;
  logic       code_ext;
  always_comb begin
    is_ext   = (kin.code == KBD_PREFIX_EXT);
    is_brk   = (kin.code == KBD_PREFIX_BRK);
    code_ext = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    hit_held = ({code_ext, kin.code} == {ext_q, key_q});
  end

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    ext_d     = ext_q;
    pressed_d = pressed_q;
    count_d   = count_q;
    if (kin.code_valid) begin
      case (state_q)
        ST_IDLE, ST_EXT: begin
          if (is_brk) begin
            state_d = (state_q == ST_EXT) ? ST_EXT_BRK : ST_BRK;
          end else if (is_ext) begin
            state_d = ST_EXT;
          end else begin
            state_d = ST_IDLE;
            // A make of the key already held is typematic repeat: no change.
            if (!(pressed_q && hit_held)) begin
              key_d     = kin.code;
              ext_d     = code_ext;
              pressed_d = 1'b1;
              count_d   = count_q + CNT_ONE;
            end
          end
        end
        default: begin
          if (!is_ext && !is_brk) begin
            state_d = ST_IDLE;
            if (hit_held) pressed_d = 1'b0;
          end
        end
      endcase
    end
  end

  logic [3:0] nib [NDIG];
  logic [7:0] raw [NDIG];

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    if (i < 2) begin : g_key
      assign nib[i] = key_q[4*i +: 4];
      assign seg_d[8*i +: 8] =
        ((BLANK_ON_RELEASE && !pressed_q) ? SEG_BLANK : raw[i]) ^ POL_MASK;
      assign seg_rst[8*i +: 8] = SEG_BLANK ^ POL_MASK;
    end else begin : g_cnt
      assign nib[i] = count_q[4*(i-2) +: 4];
      assign seg_d[8*i +: 8]   = raw[i] ^ POL_MASK;
      assign seg_rst[8*i +: 8] = 8'hC0 ^ POL_MASK;
    end
    hex7seg u_hex7seg (.nib(nib[i]), .seg_n(raw[i]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      key_q     <= 8'h00;
      ext_q     <= 1'b0;
      pressed_q <= 1'b0;
      count_q   <= '0;
      seg_q     <= seg_rst;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      ext_q     <= ext_d;
      pressed_q <= pressed_d;
      count_q   <= count_d;
      seg_q     <= seg_d;
    end
  end

  assign key_code  = key_q;
  assign key_ext   = ext_q;
  assign pressed   = pressed_q;
  assign count     = count_q;
  assign seg       = seg_q;
  assign state_dbg = state_q;
endmodule
